// File: rtl/kronos_rf_sb_pkg.sv
// Shared types and constants for the scoreboarded register file:
// RV32 base opcodes, register index width and the write-back port limit.
package kronos_rf_sb_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NWR_MAX   = 3;

   typedef enum logic [6:0] {
      INSTR_LOAD  = 7'b00_000_11,
      INSTR_MISC  = 7'b00_011_11,
      INSTR_OPIMM = 7'b00_100_11,
      INSTR_AUIPC = 7'b00_101_11,
      INSTR_STORE = 7'b01_000_11,
      INSTR_OP    = 7'b01_100_11,
      INSTR_LUI   = 7'b01_101_11,
      INSTR_BR    = 7'b11_000_11,
      INSTR_JALR  = 7'b11_001_11,
      INSTR_JAL   = 7'b11_011_11,
      INSTR_SYS   = 7'b11_100_11
   } opcode_e;

   // Stores and branches are the only formats without a destination register
   function automatic logic has_rd(input logic [6:0] op);
      return !((op == INSTR_STORE) || (op == INSTR_BR));
   endfunction

endpackage

// File: rtl/kronos_rf_sb_if.sv
// Fetch/decode/write-back bundle of the scoreboarded register file.
// master: the pipeline around the RF; slave: the RF itself.
interface kronos_rf_sb_if #(parameter int NWR = 2);
   import kronos_rf_sb_pkg::*;

   logic [31:0]              instr_data;
   logic                     instr_vld;
   logic                     instr_rdy;
   logic                     dec_vld;
   logic                     dec_rdy;
   logic [31:0]              immediate;
   logic [31:0]              regrd_rs1;
   logic [31:0]              regrd_rs2;
   logic                     regrd_rs1_en;
   logic                     regrd_rs2_en;
   logic                     regrd_illegal;
   logic                     issue_en;
   logic [REG_IDX_W-1:0]     issue_sel;
   logic [NWR*32-1:0]        regwr_data;
   logic [NWR*REG_IDX_W-1:0] regwr_sel;
   logic [NWR-1:0]           regwr_en;

   modport master (
      output instr_data, instr_vld, dec_rdy, issue_en, issue_sel,
             regwr_data, regwr_sel, regwr_en,
      input  instr_rdy, dec_vld, immediate, regrd_rs1, regrd_rs2,
             regrd_rs1_en, regrd_rs2_en, regrd_illegal
   );

   modport slave (
      input  instr_data, instr_vld, dec_rdy, issue_en, issue_sel,
             regwr_data, regwr_sel, regwr_en,
      output instr_rdy, dec_vld, immediate, regrd_rs1, regrd_rs2,
             regrd_rs1_en, regrd_rs2_en, regrd_illegal
   );

endinterface

// File: rtl/kronos_rf_sb_imm_decode.sv
// Combinational immediate and source-enable decode for RV32I formats.
// Kept standalone so a compressed-instruction front end can reuse it.
module kronos_rf_sb_imm_decode
   import kronos_rf_sb_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output logic        rs1_en,
   output logic        rs2_en
);

   opcode_e opcode;
   assign opcode = opcode_e'(instr[6:0]);

   // Select the immediate format and the source enables from the opcode
   always_comb begin
      imm    = {{21{instr[31]}}, instr[30:20]};
      rs1_en = 1'b0;
      rs2_en = 1'b0;
      case (opcode)
         INSTR_OPIMM, INSTR_LOAD, INSTR_JALR: begin
            rs1_en = 1'b1;
         end
         INSTR_OP: begin
            rs1_en = 1'b1;
            rs2_en = 1'b1;
         end
         INSTR_STORE: begin
            imm    = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            rs1_en = 1'b1;
            rs2_en = 1'b1;
         end
         INSTR_BR: begin
            imm    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            rs1_en = 1'b1;
            rs2_en = 1'b1;
         end
         INSTR_LUI, INSTR_AUIPC: begin
            imm = {instr[31:12], 12'b0};
         end
         INSTR_JAL: begin
            imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         INSTR_SYS: begin
            rs1_en = (instr[14] == 1'b0) && (instr[13:12] != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/kronos_rf_sb.sv
// Integer register file with operand latch, NWR write-back ports and a
// pending-write scoreboard that holds dec_vld low on source hazards.
module kronos_rf_sb
   import kronos_rf_sb_pkg::*;
#(
   parameter int NREG   = 32,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
)(
   input  logic          clk,
   input  logic          rstz,
   kronos_rf_sb_if.slave bus
);

   localparam int IDX_W = $clog2(NREG);

   logic [31:0]              regs [NREG];
   logic [NWR-1:0]           wr_en;
   logic [NWR*REG_IDX_W-1:0] wr_sel;
   logic [NWR*32-1:0]        wr_data;

   logic [REG_IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
   logic [31:0]          dec_imm;
   logic                 dec_rs1_en, dec_rs2_en;
   logic [32:0]          rs1_fwd, rs2_fwd, lat1_fwd, lat2_fwd;
   logic [31:0]          rs1_rd, rs2_rd;
   logic                 illegal_nxt;

   logic                 reg_vld;
   logic                 illegal_q;
   logic [31:0]          imm_q, rs1_data_q, rs2_data_q;
   logic [REG_IDX_W-1:0] rs1_q, rs2_q;
   logic                 rs1_en_q, rs2_en_q;
   logic [NREG-1:0]      busy, busy_nxt;
   logic                 rs1_busy, rs2_busy;
   logic                 dec_vld, instr_rdy, accept;

   assign wr_en   = bus.regwr_en;
   assign wr_sel  = bus.regwr_sel;
   assign wr_data = bus.regwr_data;

   assign rs1_idx = bus.instr_data[19:15];
   assign rs2_idx = bus.instr_data[24:20];
   assign rd_idx  = bus.instr_data[11:7];

   function automatic logic out_of_range(input logic [REG_IDX_W-1:0] idx);
      return int'(idx) >= NREG;
   endfunction

   function automatic logic [IDX_W-1:0] trim(input logic [REG_IDX_W-1:0] idx);
      return idx[IDX_W-1:0];
   endfunction

   // Port-priority mux: {hit, data} of the highest-index port writing idx
   function automatic logic [32:0] wb_match(
      input logic [REG_IDX_W-1:0]     idx,
      input logic [NWR-1:0]           en,
      input logic [NWR*REG_IDX_W-1:0] sel,
      input logic [NWR*32-1:0]        data
   );
      logic [32:0] r;
      r = '0;
      for (int p = 0; p < NWR; p++)
         if (en[p] && (sel[p*REG_IDX_W +: REG_IDX_W] == idx))
            r = {1'b1, data[p*32 +: 32]};
      return r;
   endfunction

   kronos_rf_sb_imm_decode u_imm_decode (
      .instr  (bus.instr_data),
      .imm    (dec_imm),
      .rs1_en (dec_rs1_en),
      .rs2_en (dec_rs2_en)
   );

   // Read ports for the incoming instruction: zero, forwarded write-back, or the array
   always_comb begin
      rs1_fwd = wb_match(rs1_idx, wr_en, wr_sel, wr_data);
      rs2_fwd = wb_match(rs2_idx, wr_en, wr_sel, wr_data);
      if ((rs1_idx == '0) || out_of_range(rs1_idx))
         rs1_rd = '0;
      else if ((BYPASS != 0) && rs1_fwd[32])
         rs1_rd = rs1_fwd[31:0];
      else
         rs1_rd = regs[trim(rs1_idx)];
      if ((rs2_idx == '0) || out_of_range(rs2_idx))
         rs2_rd = '0;
      else if ((BYPASS != 0) && rs2_fwd[32])
         rs2_rd = rs2_fwd[31:0];
      else
         rs2_rd = regs[trim(rs2_idx)];
      illegal_nxt = (dec_rs1_en && out_of_range(rs1_idx))
                  | (dec_rs2_en && out_of_range(rs2_idx))
                  | (has_rd(bus.instr_data[6:0]) && out_of_range(rd_idx));
   end

   // Write-backs seen by operands already sitting in the latch
   always_comb begin
      lat1_fwd = wb_match(rs1_q, wr_en, wr_sel, wr_data);
      lat2_fwd = wb_match(rs2_q, wr_en, wr_sel, wr_data);
      if ((rs1_q == '0) || out_of_range(rs1_q)) lat1_fwd[32] = 1'b0;
      if ((rs2_q == '0) || out_of_range(rs2_q)) lat2_fwd[32] = 1'b0;
   end

   // Scoreboard next state: write-backs clear, a new issue sets and takes precedence
   always_comb begin
      busy_nxt = busy;
      for (int p = 0; p < NWR; p++)
         if (wr_en[p] && !out_of_range(wr_sel[p*REG_IDX_W +: REG_IDX_W]))
            busy_nxt[trim(wr_sel[p*REG_IDX_W +: REG_IDX_W])] = 1'b0;
      if (bus.issue_en && (bus.issue_sel != '0) && !out_of_range(bus.issue_sel))
         busy_nxt[trim(bus.issue_sel)] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Hazard check on the latched sources, purely from registered state
   always_comb begin
      rs1_busy = rs1_en_q && !out_of_range(rs1_q) && busy[trim(rs1_q)];
      rs2_busy = rs2_en_q && !out_of_range(rs2_q) && busy[trim(rs2_q)];
   end

   assign dec_vld   = reg_vld & ~rs1_busy & ~rs2_busy;
   assign instr_rdy = ~reg_vld | (dec_vld & bus.dec_rdy);
   assign accept    = bus.instr_vld & instr_rdy;

   // Register array writes; later ports override earlier ones, x0 and out-of-range dropped
   always_ff @(posedge clk) begin
      for (int p = 0; p < NWR; p++)
         if (wr_en[p] && (wr_sel[p*REG_IDX_W +: REG_IDX_W] != '0)
             && !out_of_range(wr_sel[p*REG_IDX_W +: REG_IDX_W]))
            regs[trim(wr_sel[p*REG_IDX_W +: REG_IDX_W])] <= wr_data[p*32 +: 32];
   end

   // Operand latch: capture on accept, otherwise track write-backs to latched sources
   always_ff @(posedge clk) begin
      if (accept) begin
         imm_q      <= dec_imm;
         rs1_data_q <= rs1_rd;
         rs2_data_q <= rs2_rd;
         rs1_q      <= rs1_idx;
         rs2_q      <= rs2_idx;
         rs1_en_q   <= dec_rs1_en;
         rs2_en_q   <= dec_rs2_en;
      end else if (reg_vld) begin
         if (lat1_fwd[32]) rs1_data_q <= lat1_fwd[31:0];
         if (lat2_fwd[32]) rs2_data_q <= lat2_fwd[31:0];
      end
   end

   // Latch valid, illegal flag and scoreboard, all cleared by reset
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         reg_vld   <= 1'b0;
         illegal_q <= 1'b0;
         busy      <= '0;
      end else begin
         if (accept) begin
            reg_vld   <= 1'b1;
            illegal_q <= illegal_nxt;
         end else if (dec_vld && bus.dec_rdy) begin
            reg_vld <= 1'b0;
         end
         busy <= busy_nxt;
      end
   end

   assign bus.instr_rdy     = instr_rdy;
   assign bus.dec_vld       = dec_vld;
   assign bus.immediate     = imm_q;
   assign bus.regrd_rs1     = rs1_data_q;
   assign bus.regrd_rs2     = rs2_data_q;
   assign bus.regrd_rs1_en  = rs1_en_q;
   assign bus.regrd_rs2_en  = rs2_en_q;
   assign bus.regrd_illegal = illegal_q;

endmodule

// File: tb/tb_kronos_rf_sb.sv
// Directed bench for kronos_rf_sb: an RV32I instance (dut) and an RV32E
// instance (dut_e) share the same stimulus.
module tb_kronos_rf_sb;

   logic        clk;
   logic        rstz;
   logic [31:0] instr_data;
   logic        instr_vld;
   logic        dec_rdy;
   logic        issue_en;
   logic [4:0]  issue_sel;
   logic [63:0] regwr_data;
   logic [9:0]  regwr_sel;
   logic [1:0]  regwr_en;

   int checks = 0;
   int errors = 0;

   kronos_rf_sb_if #(.NWR(2)) bus_i ();
   kronos_rf_sb_if #(.NWR(2)) bus_e ();

   assign bus_i.instr_data = instr_data;
   assign bus_i.instr_vld  = instr_vld;
   assign bus_i.dec_rdy    = dec_rdy;
   assign bus_i.issue_en   = issue_en;
   assign bus_i.issue_sel  = issue_sel;
   assign bus_i.regwr_data = regwr_data;
   assign bus_i.regwr_sel  = regwr_sel;
   assign bus_i.regwr_en   = regwr_en;
   assign bus_e.instr_data = instr_data;
   assign bus_e.instr_vld  = instr_vld;
   assign bus_e.dec_rdy    = dec_rdy;
   assign bus_e.issue_en   = issue_en;
   assign bus_e.issue_sel  = issue_sel;
   assign bus_e.regwr_data = regwr_data;
   assign bus_e.regwr_sel  = regwr_sel;
   assign bus_e.regwr_en   = regwr_en;

   kronos_rf_sb #(.NREG(32), .NWR(2), .BYPASS(1)) dut (
      .clk  (clk),
      .rstz (rstz),
      .bus  (bus_i)
   );

   kronos_rf_sb #(.NREG(16), .NWR(2), .BYPASS(1)) dut_e (
      .clk  (clk),
      .rstz (rstz),
      .bus  (bus_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate-format vectors: LUI, ADDI -1, SW -4, BEQ -8, JAL +0x800, CSRRS, ECALL
   logic [31:0] imm_instr [7] = '{32'hABCDE537, 32'hFFF00593, 32'hFE112E23, 32'hFE000CE3,
                                  32'h001000EF, 32'h3001A073, 32'h00000073};
   logic [31:0] imm_exp   [7] = '{32'hABCDE000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                  32'h00000800, 32'h00000300, 32'h00000000};
   logic        rs1_exp   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   logic        rs2_exp   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic vld);
      instr_data = instr;
      instr_vld  = vld;
   endtask

   task automatic writeBack(input int port, input logic [4:0] sel, input logic [31:0] data);
      regwr_en[port]          = 1'b1;
      regwr_sel[port*5 +: 5]  = sel;
      regwr_data[port*32 +: 32] = data;
   endtask

   task automatic clearWriteBack();
      regwr_en = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rstz = 1'b0;
      applyStimulus(32'h0, 1'b0);
      dec_rdy    = 1'b1;
      issue_en   = 1'b0;
      issue_sel  = '0;
      regwr_data = '0;
      regwr_sel  = '0;
      regwr_en   = '0;
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("rst_dec_vld", bus_i.dec_vld, 0);
      checkOutput("rst_instr_rdy", bus_i.instr_rdy, 1);
      checkOutput("rst_illegal", bus_i.regrd_illegal, 0);
      checkOutput("rst_e_dec_vld", bus_e.dec_vld, 0);
      rstz = 1'b1;
      tick();

      $display("[TB] ADDI x1,x0,5");
      applyStimulus(32'h00500093, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("addi_imm", bus_i.immediate, 32'd5);
      checkOutput("addi_rs1", bus_i.regrd_rs1, 32'd0);
      checkOutput("addi_rs1_en", bus_i.regrd_rs1_en, 1);
      checkOutput("addi_rs2_en", bus_i.regrd_rs2_en, 0);
      checkOutput("addi_dec_vld", bus_i.dec_vld, 1);
      tick();
      checkOutput("addi_drained", bus_i.dec_vld, 0);

      $display("[TB] bypass into ADD x4,x3,x3");
      applyStimulus(32'h00318233, 1'b1);
      writeBack(0, 5'd3, 32'hA5A5_0000);
      tick();
      applyStimulus(32'h0, 1'b0);
      clearWriteBack();
      checkOutput("byp_rs1", bus_i.regrd_rs1, 32'hA5A5_0000);
      checkOutput("byp_rs2", bus_i.regrd_rs2, 32'hA5A5_0000);
      checkOutput("byp_dec_vld", bus_i.dec_vld, 1);
      tick();

      $display("[TB] scoreboard stall on SW x5,0(x2)");
      issue_en  = 1'b1;
      issue_sel = 5'd5;
      tick();
      issue_en = 1'b0;
      applyStimulus(32'h00512023, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("sw_stall0", bus_i.dec_vld, 0);
      checkOutput("sw_rdy_low", bus_i.instr_rdy, 0);
      tick();
      writeBack(1, 5'd5, 32'h77);
      checkOutput("sw_stall1", bus_i.dec_vld, 0);
      tick();
      clearWriteBack();
      checkOutput("sw_release", bus_i.dec_vld, 1);
      checkOutput("sw_rs2", bus_i.regrd_rs2, 32'h77);
      tick();

      $display("[TB] port priority on x6");
      writeBack(0, 5'd6, 32'h1);
      writeBack(1, 5'd6, 32'h2);
      tick();
      clearWriteBack();
      applyStimulus(32'h00630433, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("prio_reg_rs1", bus_i.regrd_rs1, 32'h2);
      checkOutput("prio_reg_rs2", bus_i.regrd_rs2, 32'h2);
      tick();
      applyStimulus(32'h00630433, 1'b1);
      writeBack(0, 5'd6, 32'h10);
      writeBack(1, 5'd6, 32'h20);
      tick();
      applyStimulus(32'h0, 1'b0);
      dec_rdy = 1'b0;
      writeBack(0, 5'd6, 32'h30);
      writeBack(1, 5'd6, 32'h40);
      checkOutput("prio_byp_rs1", bus_i.regrd_rs1, 32'h20);
      tick();
      clearWriteBack();
      checkOutput("prio_lat_rs1", bus_i.regrd_rs1, 32'h40);
      checkOutput("prio_lat_rs2", bus_i.regrd_rs2, 32'h40);
      dec_rdy = 1'b1;
      tick();

      $display("[TB] same-cycle issue and write-back of x7");
      issue_en  = 1'b1;
      issue_sel = 5'd7;
      tick();
      writeBack(0, 5'd7, 32'h55);
      tick();
      issue_en = 1'b0;
      clearWriteBack();
      applyStimulus(32'h000384B3, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("x7_stall0", bus_i.dec_vld, 0);
      tick();
      checkOutput("x7_stall1", bus_i.dec_vld, 0);
      writeBack(0, 5'd7, 32'h66);
      tick();
      clearWriteBack();
      checkOutput("x7_release", bus_i.dec_vld, 1);
      checkOutput("x7_rs1", bus_i.regrd_rs1, 32'h66);
      tick();

      $display("[TB] RV32E out-of-range ADD x1,x20,x2");
      issue_en  = 1'b1;
      issue_sel = 5'd20;
      tick();
      issue_en = 1'b0;
      applyStimulus(32'h002A00B3, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      dec_rdy = 1'b0;
      checkOutput("i_x20_stall", bus_i.dec_vld, 0);
      checkOutput("i_x20_legal", bus_i.regrd_illegal, 0);
      checkOutput("e_x20_dec_vld", bus_e.dec_vld, 1);
      checkOutput("e_x20_illegal", bus_e.regrd_illegal, 1);
      checkOutput("e_x20_rs1", bus_e.regrd_rs1, 32'h0);
      writeBack(0, 5'd20, 32'h1234);
      tick();
      clearWriteBack();
      checkOutput("i_x20_fwd", bus_i.regrd_rs1, 32'h1234);
      checkOutput("i_x20_release", bus_i.dec_vld, 1);
      checkOutput("e_x20_nofwd", bus_e.regrd_rs1, 32'h0);
      dec_rdy = 1'b1;
      tick();
      applyStimulus(32'h002A00B3, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("i_x20_reg", bus_i.regrd_rs1, 32'h1234);
      checkOutput("e_x20_reg", bus_e.regrd_rs1, 32'h0);
      checkOutput("e_x20_illegal2", bus_e.regrd_illegal, 1);
      tick();

      $display("[TB] immediate formats");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(imm_instr[i], 1'b1);
         tick();
         applyStimulus(32'h0, 1'b0);
         checkOutput($sformatf("imm%0d_value", i), bus_i.immediate, imm_exp[i]);
         checkOutput($sformatf("imm%0d_rs1_en", i), bus_i.regrd_rs1_en, rs1_exp[i]);
         checkOutput($sformatf("imm%0d_rs2_en", i), bus_i.regrd_rs2_en, rs2_exp[i]);
         checkOutput($sformatf("imm%0d_e_legal", i), bus_e.regrd_illegal, 0);
         tick();
      end

      $display("[TB] mid-operation reset");
      issue_en  = 1'b1;
      issue_sel = 5'd9;
      tick();
      issue_en = 1'b0;
      applyStimulus(32'h00048233, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("mr_stall", bus_i.dec_vld, 0);
      checkOutput("mr_rdy_low", bus_i.instr_rdy, 0);
      rstz = 1'b0;
      #1;
      checkOutput("mr_rdy_reset", bus_i.instr_rdy, 1);
      checkOutput("mr_dec_vld_reset", bus_i.dec_vld, 0);
      tick();
      rstz = 1'b1;
      tick();
      applyStimulus(32'h00048233, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("mr_busy_cleared", bus_i.dec_vld, 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
